// File: rtl/wb_stage.sv
// Writeback stage: arbitrates load/ALU results onto one register-file write port
// and tracks pending destinations. Optional operand bypass under WB_BYPASS_EN.
module wb_stage (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        alu_valid,
    output logic        alu_ready,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [4:0]  ld_rd,
    input  logic [31:0] ld_data,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_addr_lo,
    input  logic        iss_valid,
    input  logic [4:0]  iss_rd,
    output logic        RegWrite,
    output logic [4:0]  wr,
    output logic [31:0] wd,
    output logic [31:0] busy
`ifdef WB_BYPASS_EN
    ,
    input  logic [4:0]  rr1,
    input  logic [4:0]  rr2,
    output logic        byp1_hit,
    output logic [31:0] byp1_data,
    output logic        byp2_hit,
    output logic [31:0] byp2_data
`endif
);

    function automatic logic [31:0] load_extract(input logic [31:0] data,
                                                 input logic [2:0]  funct3,
                                                 input logic [1:0]  lo);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lo)
            2'd0:    b = data[7:0];
            2'd1:    b = data[15:8];
            2'd2:    b = data[23:16];
            2'd3:    b = data[31:24];
            default: b = data[7:0];
        endcase
        h = lo[1] ? data[31:16] : data[15:0];
        case (funct3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b100:  r = {24'd0, b};
            3'b101:  r = {16'd0, h};
            default: r = data;
        endcase
        return r;
    endfunction

    logic        regwrite_q, regwrite_d;
    logic [4:0]  wr_q, wr_d;
    logic [31:0] wd_q, wd_d;
    logic [31:0] busy_q, busy_d;
    logic        ld_fire_s, alu_fire_s;

    // Handshake: loads always win, so the ALU side stalls whenever a load is offered.
    assign ld_ready   = reset_n;
    assign alu_ready  = reset_n & ~ld_valid;
    assign ld_fire_s  = ld_valid & ld_ready;
    assign alu_fire_s = alu_valid & alu_ready;

    // Next-state for the write port and the pending-write bitmap.
    always_comb begin
        regwrite_d = 1'b0;
        wr_d       = wr_q;
        wd_d       = wd_q;
        if (ld_fire_s) begin
            regwrite_d = (ld_rd != 5'd0);
            wr_d       = ld_rd;
            wd_d       = load_extract(ld_data, ld_funct3, ld_addr_lo);
        end else if (alu_fire_s) begin
            regwrite_d = (alu_rd != 5'd0);
            wr_d       = alu_rd;
            wd_d       = alu_data;
        end else begin
            regwrite_d = 1'b0;
        end

        busy_d = busy_q;
        if (regwrite_q) begin
            busy_d[wr_q] = 1'b0;
        end else begin
            busy_d = busy_q;
        end
        // Applied after the clear so a same-register reservation survives.
        if (iss_valid) begin
            busy_d[iss_rd] = 1'b1;
        end else begin
            busy_d = busy_d;
        end
        busy_d[0] = 1'b0;
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            regwrite_q <= 1'b0;
            wr_q       <= 5'd0;
            wd_q       <= 32'd0;
            busy_q     <= 32'd0;
        end else begin
            regwrite_q <= regwrite_d;
            wr_q       <= wr_d;
            wd_q       <= wd_d;
            busy_q     <= busy_d;
        end
    end

    assign RegWrite = regwrite_q;
    assign wr       = wr_q;
    assign wd       = wd_q;
    assign busy     = busy_q;

`ifdef WB_BYPASS_EN
    assign byp1_hit  = regwrite_q & (wr_q == rr1) & (rr1 != 5'd0);
    assign byp1_data = wd_q;
    assign byp2_hit  = regwrite_q & (wr_q == rr2) & (rr2 != 5'd0);
    assign byp2_data = wd_q;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: load-extract vector table, directed corner
// sequences and randomized traffic against a behavioural model.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        alu_valid, alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ld_valid, ld_ready;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic [2:0]  ld_funct3;
    logic [1:0]  ld_addr_lo;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic        RegWrite;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic [31:0] busy;
`ifdef WB_BYPASS_EN
    logic [4:0]  rr1, rr2;
    logic        byp1_hit, byp2_hit;
    logic [31:0] byp1_data, byp2_data;
`endif

    always #5 clk = ~clk;

    wb_stage dut (
        .clk(clk), .reset_n(reset_n),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
        .ld_funct3(ld_funct3), .ld_addr_lo(ld_addr_lo),
        .iss_valid(iss_valid), .iss_rd(iss_rd),
        .RegWrite(RegWrite), .wr(wr), .wd(wd), .busy(busy)
`ifdef WB_BYPASS_EN
        , .rr1(rr1), .rr2(rr2), .byp1_hit(byp1_hit), .byp1_data(byp1_data),
        .byp2_hit(byp2_hit), .byp2_data(byp2_data)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: what the write port and bitmap should show after each edge.
    logic        m_rw;
    logic [4:0]  m_wr;
    logic [31:0] m_wd;
    logic [31:0] m_busy;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [31:0] d, input logic [2:0] f,
                                             input logic [1:0] a);
        logic [31:0] b, h;
        b = (d >> ({30'd0, a} * 32'd8)) & 32'h0000_00FF;
        h = (d >> ({31'd0, a[1]} * 32'd16)) & 32'h0000_FFFF;
        case (f)
            3'd0:    return (b >= 32'd128) ? b + 32'hFFFF_FF00 : b;
            3'd1:    return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return d;
        endcase
    endfunction

    task automatic idle_inputs();
        alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
        ld_valid = 1'b0; ld_rd = 5'd0; ld_data = 32'd0; ld_funct3 = 3'd0; ld_addr_lo = 2'd0;
        iss_valid = 1'b0; iss_rd = 5'd0;
`ifdef WB_BYPASS_EN
        rr1 = 5'd0; rr2 = 5'd0;
`endif
    endtask

    // Inputs are set just after a negedge; advance one edge, update the model, compare.
    task automatic cycle();
        logic [31:0] nb;
        #1;
        chk("alu_ready", {31'd0, alu_ready}, {31'd0, ~ld_valid});
        chk("ld_ready", {31'd0, ld_ready}, 32'd1);
`ifdef WB_BYPASS_EN
        chk("byp1_hit", {31'd0, byp1_hit}, {31'd0, m_rw && m_wr == rr1 && rr1 != 5'd0});
        chk("byp2_hit", {31'd0, byp2_hit}, {31'd0, m_rw && m_wr == rr2 && rr2 != 5'd0});
        if (m_rw) chk("byp1_data", byp1_data, m_wd);
`endif
        nb = m_busy;
        if (m_rw) nb = nb & ~(32'd1 << m_wr);
        if (iss_valid) nb = nb | (32'd1 << iss_rd);
        m_busy = nb & 32'hFFFF_FFFE;
        if (ld_valid) begin
            m_rw = (ld_rd != 5'd0); m_wr = ld_rd; m_wd = ref_load(ld_data, ld_funct3, ld_addr_lo);
        end else if (alu_valid) begin
            m_rw = (alu_rd != 5'd0); m_wr = alu_rd; m_wd = alu_data;
        end else begin
            m_rw = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        chk("RegWrite", {31'd0, RegWrite}, {31'd0, m_rw});
        chk("busy", busy, m_busy);
        if (m_rw) begin
            chk("wr", {27'd0, wr}, {27'd0, m_wr});
            chk("wd", wd, m_wd);
        end
    endtask

    typedef struct {
        logic [31:0] data;
        logic [2:0]  f3;
        logic [1:0]  lo;
        logic [31:0] exp;
    } ld_vec_t;

    ld_vec_t vecs[8];

    initial begin
        vecs[0] = '{32'h80FF7F01, 3'b000, 2'd3, 32'hFFFFFF80};
        vecs[1] = '{32'h80FF7F01, 3'b100, 2'd3, 32'h00000080};
        vecs[2] = '{32'h80FF7F01, 3'b001, 2'd2, 32'hFFFF80FF};
        vecs[3] = '{32'h80FF7F01, 3'b101, 2'd0, 32'h00007F01};
        vecs[4] = '{32'h80FF7F01, 3'b010, 2'd1, 32'h80FF7F01};
        vecs[5] = '{32'h80FF7F01, 3'b000, 2'd1, 32'h0000007F};
        vecs[6] = '{32'h80FF7F01, 3'b101, 2'd2, 32'h000080FF};
        vecs[7] = '{32'h80FF7F01, 3'b011, 2'd2, 32'h80FF7F01};

        idle_inputs();
        reset_n = 1'b0;
        m_rw = 1'b0; m_wr = 5'd0; m_wd = 32'd0; m_busy = 32'd0;
        #23;
        chk("rst RegWrite", {31'd0, RegWrite}, 32'd0);
        chk("rst wr", {27'd0, wr}, 32'd0);
        chk("rst wd", wd, 32'd0);
        chk("rst busy", busy, 32'd0);
        chk("rst ld_ready", {31'd0, ld_ready}, 32'd0);
        chk("rst alu_ready", {31'd0, alu_ready}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // ALU write, then hold of wr/wd with RegWrite low.
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h12345678;
        cycle();
        chk("alu wd", wd, 32'h12345678);
        idle_inputs();
        cycle();
        chk("hold wr", {27'd0, wr}, 32'd5);
        chk("hold wd", wd, 32'h12345678);

        // Load extraction table.
        for (int i = 0; i < 8; i++) begin
            idle_inputs();
            ld_valid = 1'b1; ld_rd = 5'(10 + i); ld_data = vecs[i].data;
            ld_funct3 = vecs[i].f3; ld_addr_lo = vecs[i].lo;
            cycle();
            chk("ld vec wd", wd, vecs[i].exp);
        end

        // Load beats ALU; ALU goes the cycle after the load drops.
        idle_inputs();
        ld_valid = 1'b1; ld_rd = 5'd3; ld_data = 32'hCAFE0001; ld_funct3 = 3'b010;
        alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h0000BEEF;
        cycle();
        chk("arb first wr", {27'd0, wr}, 32'd3);
        ld_valid = 1'b0;
        cycle();
        chk("arb second wr", {27'd0, wr}, 32'd4);
        chk("arb second wd", wd, 32'h0000BEEF);

        // Reservation vs. clear on the same register.
        idle_inputs();
        iss_valid = 1'b1; iss_rd = 5'd7;
        cycle();
        chk("busy7 set", {31'd0, busy[7]}, 32'd1);
        idle_inputs();
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h77;
        cycle();
        idle_inputs();
        iss_valid = 1'b1; iss_rd = 5'd7;
        cycle();
        chk("busy7 kept", {31'd0, busy[7]}, 32'd1);
        iss_rd = 5'd0;
        cycle();
        chk("busy0", {31'd0, busy[0]}, 32'd0);

        // Write to x0 is accepted but never asserts RegWrite.
        idle_inputs();
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hDEADBEEF;
        cycle();
        chk("x0 RegWrite", {31'd0, RegWrite}, 32'd0);

`ifdef WB_BYPASS_EN
        idle_inputs();
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h99990000;
        cycle();
        idle_inputs();
        rr1 = 5'd9; rr2 = 5'd0;
        #1;
        chk("byp1 hit", {31'd0, byp1_hit}, 32'd1);
        chk("byp1 data", byp1_data, 32'h99990000);
        chk("byp2 hit", {31'd0, byp2_hit}, 32'd0);
        cycle();
`endif

        // Reset asserted while a write is on the port.
        idle_inputs();
        alu_valid = 1'b1; alu_rd = 5'd6; alu_data = 32'h66;
        iss_valid = 1'b1; iss_rd = 5'd12;
        @(posedge clk);
        #1;
        chk("pre-rst RegWrite", {31'd0, RegWrite}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("mid-rst RegWrite", {31'd0, RegWrite}, 32'd0);
        chk("mid-rst busy", busy, 32'd0);
        chk("mid-rst wr", {27'd0, wr}, 32'd0);
        chk("mid-rst alu_ready", {31'd0, alu_ready}, 32'd0);
        chk("mid-rst ld_ready", {31'd0, ld_ready}, 32'd0);
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        reset_n = 1'b1;
        m_rw = 1'b0; m_wr = 5'd0; m_wd = 32'd0; m_busy = 32'd0;
        cycle();
        chk("post-rst RegWrite", {31'd0, RegWrite}, 32'd0);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            alu_valid  = 1'($urandom_range(0, 1));
            alu_rd     = 5'($urandom);
            alu_data   = $urandom;
            ld_valid   = ($urandom_range(0, 2) == 0);
            ld_rd      = 5'($urandom);
            ld_data    = $urandom;
            ld_funct3  = 3'($urandom);
            ld_addr_lo = 2'($urandom);
            iss_valid  = 1'($urandom_range(0, 1));
            iss_rd     = ($urandom_range(0, 3) == 0) ? m_wr : 5'($urandom);
`ifdef WB_BYPASS_EN
            rr1 = ($urandom_range(0, 1) == 0) ? m_wr : 5'($urandom);
            rr2 = ($urandom_range(0, 1) == 0) ? m_wr : 5'($urandom);
`endif
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
